// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between core load/store and host port
//
// Shares one single-port data RAM between the core's load/store path and a
// host (debug/loader/DMA) port. The core wins by default. A saturating wait
// counter guarantees the host a slot after STARVE_LIMIT contended cycles.
// A beat counter caps a host burst at MAX_BURST beats, followed by one
// cool-down cycle in which the core is preferred.
//
// Optional feature macro: DMEM_ARB_PERF_CNT_EN
//   defined   : 16-bit saturating stall / host-beat performance counters
//   undefined : perf outputs tie to zero, no counter flops
//
// Ports:
//   clk              system clock, rising edge
//   areset           asynchronous reset, active-low
//   core_req/we      core access request / write enable
//   core_addr/wdata  core word address / write data
//   core_rdata       combinational passthrough of mem_rdata
//   core_stall       core requested but the host owns the memory
//   host_valid/we    host request valid / write enable
//   host_addr/wdata  host word address / write data
//   host_ready       host beat accepted this cycle
//   host_rvalid      one-cycle pulse, registered host read data valid
//   host_rdata       registered host read data
//   mem_addr/we/wdata  to RAM
//   mem_rdata        RAM combinational read data
//   perf_core_stall  cycles with core_stall=1 (optional)
//   perf_host_beats  cycles with host_ready=1 (optional)

module dmem_arbiter #(
   parameter int AW           = 30,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 4
) (
   input  logic          clk,
   input  logic          areset,

   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,

   input  logic          host_valid,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ready,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,

   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,

   output logic [15:0]   perf_core_stall,
   output logic [15:0]   perf_host_beats
);

   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [WW-1:0] WAIT_MAX  = WW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

   typedef enum logic [1:0] {
      ARB_CORE = 2'd0,
      ARB_HOST = 2'd1,
      ARB_COOL = 2'd2
   } arb_state_t;

   arb_state_t    state;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] beat_cnt;

   logic grant_host_raw;
   logic grant_host;
   logic grant_core;

   // Host grant rule per arbiter state.
   always_comb begin
      grant_host_raw = 1'b0;
      case (state)
         ARB_CORE: grant_host_raw = host_valid && (!core_req || (wait_cnt == WAIT_MAX));
         ARB_HOST: grant_host_raw = host_valid;
         ARB_COOL: grant_host_raw = host_valid && !core_req;
         default:  grant_host_raw = 1'b0;
      endcase
   end

   // While in reset nothing may be granted, so no write can reach the RAM and
   // neither side sees a handshake or a stall.
   assign grant_host = grant_host_raw && areset;
   assign grant_core = core_req && !grant_host && areset;

   assign host_ready = grant_host;
   assign core_stall = core_req && grant_host;
   assign core_rdata = mem_rdata;

   // With no grant the core side drives address/data so a plain core read
   // stays a single combinational path.
   always_comb begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = 1'b0;
      if (grant_host) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_we    = host_we;
      end else if (grant_core) begin
         mem_we    = core_we;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state       <= ARB_CORE;
         wait_cnt    <= '0;
         beat_cnt    <= '0;
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         // Host read data is captured from the RAM in the granted cycle and
         // presented for exactly one cycle afterwards.
         if (grant_host && !host_we) begin
            host_rvalid <= 1'b1;
            host_rdata  <= mem_rdata;
         end else begin
            host_rvalid <= 1'b0;
         end

         case (state)
            ARB_CORE: begin
               if (grant_host) begin
                  // A single-beat burst limit goes straight to cool-down.
                  state    <= (MAX_BURST == 1) ? ARB_COOL : ARB_HOST;
                  beat_cnt <= BEAT_ONE;
                  wait_cnt <= '0;
               end else if (host_valid && core_req) begin
                  if (wait_cnt != WAIT_MAX) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end else begin
                  wait_cnt <= '0;
               end
            end

            ARB_HOST: begin
               if (!host_valid) begin
                  // Burst ended early by the host: no cool-down penalty.
                  state    <= ARB_CORE;
                  beat_cnt <= '0;
               end else if (beat_cnt == BEAT_LAST) begin
                  state    <= ARB_COOL;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end

            ARB_COOL: begin
               state    <= ARB_CORE;
               beat_cnt <= '0;
               wait_cnt <= '0;
            end

            default: begin
               state    <= ARB_CORE;
               beat_cnt <= '0;
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef DMEM_ARB_PERF_CNT_EN
   logic [15:0] stall_cycles;
   logic [15:0] host_beats;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         stall_cycles <= '0;
         host_beats   <= '0;
      end else begin
         if (core_stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         if (host_ready && (host_beats != 16'hFFFF)) begin
            host_beats <= host_beats + 16'd1;
         end
      end
   end

   assign perf_core_stall = stall_cycles;
   assign perf_host_beats = host_beats;
`else
   assign perf_core_stall = 16'd0;
   assign perf_host_beats = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int MAX_BURST = 4;

   logic          clk;
   logic          areset;
   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;
   logic          core_stall;
   logic          host_valid;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_ready;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [15:0]   perf_core_stall;
   logic [15:0]   perf_host_beats;

   dmem_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .areset(areset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
      .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .perf_core_stall(perf_core_stall), .perf_host_beats(perf_host_beats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM behind the arbiter (environment) and the reference memory image.
   logic [DW-1:0] ram [64];
   logic [DW-1:0] ref_mem [64];
   assign mem_rdata = ram[mem_addr[5:0]];

   int checks = 0;
   int errors = 0;

   // Reference model: burst length so far (MAX_BURST means cool-down cycle)
   // and number of contended cycles the host has lost in a row.
   int burst_len = 0;
   int losses = 0;
   bit exp_rv = 0;
   logic [DW-1:0] exp_rdata = '0;
   int perf_stall_n = 0;
   int perf_beat_n = 0;
   bit host_won = 0;
   bit core_held = 0;
   bit host_held = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] perf_exp(input int n);
`ifdef DMEM_ARB_PERF_CNT_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return (n < 0) ? 16'hFFFF : 16'd0;
`endif
   endfunction

   // Called at posedge+1 with inputs set; returns at next posedge+1.
   task automatic do_cycle();
      bit hw, cw;
      logic          w_we;
      logic [5:0]    w_addr;
      logic [DW-1:0] w_data;
      #1;
      if (burst_len == MAX_BURST)     hw = host_valid && !core_req;
      else if (burst_len > 0)         hw = host_valid;
      else                            hw = host_valid && (!core_req || losses >= STARVE_LIMIT);
      cw = core_req && !hw;
      host_won = hw;

      check_eq("host_ready", 32'(host_ready), 32'(hw));
      check_eq("core_stall", 32'(core_stall), 32'(core_req && hw));
      check_eq("mem_we", 32'(mem_we), 32'(hw ? host_we : (cw ? core_we : 1'b0)));
      check_eq("mem_addr", 32'(mem_addr), 32'(hw ? host_addr : core_addr));
      if (hw && host_we) check_eq("mem_wdata_h", mem_wdata, host_wdata);
      if (cw && core_we) check_eq("mem_wdata_c", mem_wdata, core_wdata);
      if (cw && !core_we) check_eq("core_rdata", core_rdata, ref_mem[core_addr[5:0]]);
      check_eq("perf_stall", 32'(perf_core_stall), 32'(perf_exp(perf_stall_n)));
      check_eq("perf_beats", 32'(perf_host_beats), 32'(perf_exp(perf_beat_n)));

      exp_rv = hw && !host_we;
      if (exp_rv) exp_rdata = ref_mem[host_addr[5:0]];
      if (core_req && hw) perf_stall_n++;
      if (hw) perf_beat_n++;
      core_held = core_req && hw;
      host_held = host_valid && !hw;

      if (hw && host_we)      ref_mem[host_addr[5:0]] = host_wdata;
      else if (cw && core_we) ref_mem[core_addr[5:0]] = core_wdata;

      if (burst_len == MAX_BURST) begin
         burst_len = 0;
         losses = 0;
      end else if (burst_len > 0) begin
         burst_len = host_valid ? burst_len + 1 : 0;
      end else if (hw) begin
         burst_len = 1;
         losses = 0;
      end else if (host_valid && core_req) begin
         if (losses < STARVE_LIMIT) losses++;
      end else begin
         losses = 0;
      end

      w_we = mem_we; w_addr = mem_addr[5:0]; w_data = mem_wdata;
      @(posedge clk);
      if (w_we) ram[w_addr] = w_data;
      #1;
      check_eq("host_rvalid", 32'(host_rvalid), 32'(exp_rv));
      if (exp_rv) check_eq("host_rdata", host_rdata, exp_rdata);
   endtask

   task automatic do_reset();
      areset = 1'b0;
      #1;
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_host_ready", 32'(host_ready), 32'd0);
      check_eq("rst_core_stall", 32'(core_stall), 32'd0);
      check_eq("rst_host_rvalid", 32'(host_rvalid), 32'd0);
      check_eq("rst_perf_stall", 32'(perf_core_stall), 32'd0);
      check_eq("rst_perf_beats", 32'(perf_host_beats), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      areset = 1'b1;
      burst_len = 0; losses = 0; exp_rv = 0;
      perf_stall_n = 0; perf_beat_n = 0;
      core_held = 0; host_held = 0;
   endtask

   task automatic set_core(input bit req, input bit we, input int addr, input logic [31:0] data);
      core_req = req; core_we = we; core_addr = AW'(addr); core_wdata = data;
   endtask

   task automatic set_host(input bit vld, input bit we, input int addr, input logic [31:0] data);
      host_valid = vld; host_we = we; host_addr = AW'(addr); host_wdata = data;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 64; i++) begin
         ram[i] = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[32] = 32'h0000_1234;
      ref_mem[32] = 32'h0000_1234;

      areset = 1'b1;
      set_core(1, 0, 1, 0);
      set_host(1, 0, 2, 0);
      @(posedge clk);
      #1;
      do_reset();

      // Core-only write then read back the same cycle.
      set_host(0, 0, 0, 0);
      set_core(1, 1, 16, 32'hDEAD_BEEF);
      do_cycle();
      set_core(1, 0, 16, 0);
      do_cycle();
      check_eq("core_rd_0x10", core_rdata, 32'hDEAD_BEEF);

      // Host-only read of 0x20.
      set_core(0, 0, 0, 0);
      set_host(1, 0, 32, 0);
      do_cycle();
      set_host(0, 0, 0, 0);
      check_eq("host_rd_0x20", host_rdata, 32'h0000_1234);
      do_cycle();
      set_core(1, 0, 3, 0);
      do_cycle();

      // Full contention from cycle 0: 4 core, 4 host, then period 9.
      do_reset();
      set_core(1, 0, 5, 0);
      set_host(1, 0, 6, 0);
      for (int c = 0; c < 22; c++) begin
         do_cycle();
         check_eq("contend_pattern", 32'(host_won), 32'((c >= 4) && (((c - 4) % 9) < 4)));
      end

      // Early-terminated host burst, then starvation count restarts.
      do_reset();
      set_core(0, 0, 0, 0);
      set_host(1, 0, 7, 0);
      do_cycle();
      do_cycle();
      set_host(0, 0, 0, 0);
      do_cycle();
      set_core(1, 0, 8, 0);
      set_host(1, 0, 9, 0);
      n = 0;
      for (int c = 0; c < 8 && !host_won; c++) begin
         do_cycle();
         if (!host_won) n++;
      end
      check_eq("early_drop_wait", 32'(n), 32'd4);

      // Reset during a host read beat.
      do_reset();
      set_core(0, 0, 0, 0);
      set_host(1, 0, 10, 0);
      do_cycle();
      do_reset();
      check_eq("rst_burst_rvalid", 32'(host_rvalid), 32'd0);
      set_core(1, 0, 11, 0);
      set_host(1, 0, 12, 0);
      for (int c = 0; c < 5; c++) begin
         do_cycle();
         check_eq("post_rst_core_first", 32'(host_won), 32'(c == 4));
      end

      // Randomized traffic with protocol-respecting hold rules.
      for (int c = 0; c < 4000; c++) begin
         int pc, ph;
         pc = (c < 2000) ? 55 : 90;
         ph = (c < 2000) ? 45 : 85;
         if (!core_held)
            set_core($urandom_range(0, 99) < pc, $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
         if (!host_held)
            set_host($urandom_range(0, 99) < ph, $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
         if ($urandom_range(0, 699) == 0) do_reset();
         else do_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core's load/store path and a host (debug/loader/DMA) port.
- Core has priority by default. A starvation counter guarantees the host a slot, and a burst limit bounds how long the host can hold the memory.
- Core load data passes through combinationally so single-cycle loads still work. Host reads return one cycle later, registered.
- Sits between the core datapath and the data RAM. core_stall gates the PC load and register write-back.

Parameters:
- AW, 30, word-address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, contended cycles the host waits before it wins (min 1).
- MAX_BURST, 4, maximum consecutive host beats before a forced core cycle (min 1).

Ports:
- clk  in  1  system clock, rising edge
- areset  in  1  asynchronous reset, active-low
- core_req  in  1  core memory access this cycle
- core_we  in  1  core write
- core_addr  in  AW  core word address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  mem_rdata passthrough
- core_stall  out  1  core_req high and core not granted
- host_valid  in  1  host request valid
- host_we  in  1  host write
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_ready  out  1  host beat accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DW  registered host read data
- mem_addr  out  AW  to RAM
- mem_we  out  1  to RAM
- mem_wdata  out  DW  to RAM
- mem_rdata  in  DW  RAM combinational read data
- perf_core_stall  out  16  see Optional Feature
- perf_host_beats  out  16  see Optional Feature

Behaviour:
- State register: ARB_CORE, ARB_HOST, ARB_COOL. Counters: wait_cnt (0..STARVE_LIMIT, saturating) and beat_cnt (0..MAX_BURST).
- Reset (areset=0, asynchronous): state=ARB_CORE, both counters=0, host_rvalid=0, host_rdata=0. While areset=0, mem_we, host_ready and core_stall are forced to 0.
- Host grant (combinational):
  - ARB_CORE: host_valid && (!core_req || wait_cnt==STARVE_LIMIT).
  - ARB_HOST: host_valid.
  - ARB_COOL: host_valid && !core_req.
- Core grant = core_req && !grant_host.
- Outputs:
  - host_ready = grant_host.
  - core_stall = core_req && grant_host.
  - Memory signals are muxed from the granted requester.
  - With no grant: mem_we=0, mem_addr=core_addr, mem_wdata=core_wdata.
  - core_rdata = mem_rdata at all times.
- ARB_CORE transitions:
  - On grant_host: if MAX_BURST==1 go ARB_COOL, else go ARB_HOST. Set beat_cnt=1, wait_cnt=0.
  - Otherwise, if host_valid && core_req: wait_cnt++.
  - Otherwise: wait_cnt=0.
- ARB_HOST transitions:
  - If !host_valid: go ARB_CORE, beat_cnt=0. A burst ends early with no penalty.
  - Else if beat_cnt==MAX_BURST-1: this beat is the last; go ARB_COOL.
  - Else: beat_cnt++.
- ARB_COOL: lasts exactly one cycle, then ARB_CORE with beat_cnt=0 and wait_cnt=0.
- Host read: on any cycle with grant_host && !host_we, capture host_rdata<=mem_rdata and set host_rvalid=1 on the next edge. host_rvalid is otherwise 0 (one-cycle pulse per read beat).
- Back-to-back host reads produce back-to-back host_rvalid pulses.
- Host write: completes in the accepted cycle; no response.
- Simultaneous core and host access to the same address: only the granted side touches memory. The loser retries; its request must be held stable while stalled.
- Host must hold host_valid and its payload stable until host_ready.
- Reset during a burst: immediate return to ARB_CORE. A pending host_rvalid is cleared and not delivered.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined:
  - perf_core_stall counts cycles with core_stall=1.
  - perf_host_beats counts cycles with host_ready=1.
  - Both are 16-bit, saturate at 0xFFFF and clear on reset.
- Undefined: both ports tie to 0 and no counter flops are built.

Test Plan (STARVE_LIMIT=4, MAX_BURST=4):
- areset=0 with core_req=1, host_valid=1 -> mem_we=0, host_ready=0, core_stall=0, host_rvalid=0. Release -> state ARB_CORE, core granted first.
- Core-only write, addr 0x10, data 0xDEADBEEF -> mem_we=1 and mem_addr=0x10 that cycle, core_stall=0. A later core read of 0x10 returns 0xDEADBEEF the same cycle.
- Host-only read of 0x20 holding 0x00001234 -> host_ready=1 in cycle N; host_rvalid=1 with host_rdata=0x00001234 in N+1 and 0 in N+2.
- core_req and host_valid both held high from cycle 0:
  - Core granted cycles 0-3.
  - Host granted cycles 4-7 (core_stall=1).
  - Core granted cycles 8-12, host 13-16; the pattern repeats with period 9.
- Host burst with host_valid dropped after 2 beats -> ARB_CORE the next cycle. The next contention needs 4 more core cycles before the host wins.
- areset pulsed low during a host read beat -> host_rvalid stays 0, state ARB_CORE. With DMEM_ARB_PERF_CNT_EN defined, both perf counters read 0 after reset.
